guvm_icache_responder: RTL and testbench
========================================

Name: guvm_icache_responder

Overview:
Instruction-side memory responder that sits directly upstream of the integer unit's instruction-cache input in the GUVM LEON testbench.
- The sequence driver pushes instruction words into an internal FIFO.
- The block answers each core fetch with the FIFO head, honouring a configurable wait-state count via the hold signal.
- When the FIFO is empty it returns NOP.
- It replaces direct per-cycle writes of icache data from the bench with a handshaked, timing-accurate source.

Parameters:
DEPTH, 16, instruction FIFO entries (power of two, >=2)
WAIT_STATES, 0, stall cycles inserted before each response (0..15)
NOP_INST, 32'h01000000, word returned when FIFO empty

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
wr_valid  input  1  driver offers instruction
wr_inst  input  32  instruction word to enqueue
wr_ready  output  1  FIFO can accept (= not full)
fetch_req  input  1  core requests instruction
fetch_addr  input  32  fetch PC from core
flush  input  1  discard FIFO and any pending fetch
ic_data  output  32  instruction to core
ic_hold  output  1  1 = no stall / data valid, 0 = core must stall
resp_valid  output  1  one-cycle pulse when ic_data carries a new response
resp_addr  output  32  fetch_addr of the response on ic_data
fifo_count  output  $clog2(DEPTH)+1  current occupancy
nop_count  output  16  NOP responses issued, saturating at 16'hFFFF

Behaviour:
Reset (rst=1 at posedge clk):
- state=IDLE, FIFO empty, ic_data=NOP_INST, ic_hold=1, resp_valid=0, resp_addr=0, fifo_count=0, nop_count=0.
- Reset asserted mid-WAIT abandons the pending fetch with no response.

FIFO:
- Push when wr_valid & wr_ready.
- Pop only when a response is issued with the FIFO non-empty.
- Push and pop in the same cycle are both performed; count unchanged. Full plus pop plus push is legal.
- A push into an empty FIFO is not bypassed to a same-cycle response; that response is NOP.
- Pointers wrap modulo DEPTH.

FSM states IDLE, WAIT, RESP:
- A fetch is accepted when fetch_req=1 in IDLE or RESP; fetch_addr is latched.
- WAIT_STATES=0: next state is RESP, and the response is registered in the following cycle. Latency 1 cycle; throughput 1 fetch per cycle.
- WAIT_STATES=N>0: next state is WAIT with counter=N.
  - ic_hold=0 for exactly N cycles.
  - The counter decrements each cycle; at 1, next state is RESP.
  - Latency is N+1 cycles.
- fetch_req during WAIT is ignored.
- RESP lasts one cycle:
  - ic_data = FIFO head, or NOP_INST if empty (nop_count++).
  - resp_valid=1, resp_addr = latched address, ic_hold=1.
  - Next state: IDLE, or a new accept if fetch_req=1.
- Outside RESP: resp_valid=0; ic_data and resp_addr hold their last values.

flush (priority below rst, above all else):
- Empties FIFO and ignores a same-cycle push.
- Aborts WAIT; state goes to IDLE.
- ic_hold=1 next cycle; no response issued; nop_count unchanged.

Output rules:
- All outputs are registered except wr_ready and fifo_count, which derive from registered pointers.

Test Plan:
- Reset, WAIT_STATES=0: push 32'hC2002000, 32'h82102005; fetch_req at addresses 0x40000000, 0x40000004 on consecutive cycles -> resp_valid in the two following cycles with those words and addresses; ic_hold stays 1; fifo_count 2->0.
- WAIT_STATES=3: one pushed word, single fetch -> ic_hold=0 for exactly 3 cycles, then RESP on cycle 4 with ic_hold=1 and resp_valid=1.
- Empty FIFO, 3 fetches -> ic_data=32'h01000000 each time, nop_count=3; push plus fetch in the same cycle on an empty FIFO -> NOP returned, fifo_count=1 afterwards.
- Fill to DEPTH=16 -> wr_ready=0; a fetch plus wr_valid in the same cycle -> both occur, fifo_count stays 16; the 17th word is returned after 16 further pops; pointer wrap is verified.
- WAIT_STATES=3, flush in the 2nd wait cycle -> no resp_valid, ic_hold=1 next cycle, fifo_count=0, nop_count unchanged.
- rst asserted mid-WAIT with 5 words queued -> all outputs at reset values next cycle; a subsequent fetch returns NOP.

Source files
------------

// File: rtl/guvm_icache_responder.sv
// Instruction-side responder: queues driver-supplied words and answers core
// fetches from the FIFO head (NOP when empty) after a fixed number of stall cycles.
module guvm_icache_responder #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_INST    = 32'h01000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_inst,
  output logic                     wr_ready,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  input  logic                     flush,
  output logic [31:0]              ic_data,
  output logic                     ic_hold,
  output logic                     resp_valid,
  output logic [31:0]              resp_addr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              nop_count
);
  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]   WS_L     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]   mem_q [DEPTH];
  logic          issue, empty, full, pop, push;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (fifo_count == FULL_CNT);
  assign wr_ready   = ~full;
  assign pop        = issue & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a word then.
  assign push       = wr_valid & (~full | pop) & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          issue   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (fetch_req) begin
          addr_d = fetch_addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            issue   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_L;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ic_data    <= NOP_INST;
      ic_hold    <= 1'b1;
      resp_valid <= 1'b0;
      resp_addr  <= 32'd0;
      nop_count  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      resp_valid <= issue;
      ic_hold    <= (state_d != WAIT);
      if (issue) begin
        ic_data   <= empty ? NOP_INST : mem_q[rd_ptr_q[AW-1:0]];
        resp_addr <= addr_d;
        if (empty && nop_count != 16'hFFFF) nop_count <= nop_count + 16'd1;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_inst;
  end

endmodule

// File: tb/tb_guvm_icache_responder.sv
// Bench for guvm_icache_responder: two instances (0 and 3 wait states) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_guvm_icache_responder;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h01000000;

  logic clk = 1'b0;
  logic rst, wr_valid, fetch_req, flush;
  logic [31:0] wr_inst, fetch_addr;

  logic [1:0]       wr_ready, ic_hold, resp_valid;
  logic [1:0][31:0] ic_data, resp_addr;
  logic [1:0][4:0]  fifo_count;
  logic [1:0][15:0] nop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  guvm_icache_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .NOP_INST(NOP)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_inst(wr_inst), .wr_ready(wr_ready[0]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .ic_data(ic_data[0]), .ic_hold(ic_hold[0]), .resp_valid(resp_valid[0]),
    .resp_addr(resp_addr[0]), .fifo_count(fifo_count[0]), .nop_count(nop_count[0]));

  guvm_icache_responder #(.DEPTH(DEPTH), .WAIT_STATES(3), .NOP_INST(NOP)) dut3 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_inst(wr_inst), .wr_ready(wr_ready[1]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .ic_data(ic_data[1]), .ic_hold(ic_hold[1]), .resp_valid(resp_valid[1]),
    .resp_addr(resp_addr[1]), .fifo_count(fifo_count[1]), .nop_count(nop_count[1]));

  // Reference model: a queue of words plus a countdown until the pending response.
  int          ws [2] = '{0, 3};
  logic [31:0] mq [2][$];
  int          m_rem [2];
  int          m_nop [2];
  logic [31:0] m_addr [2], m_data [2], m_raddr [2];
  logic        m_rv [2], m_hold [2];

  task automatic model_step(input int k);
    bit issue;
    issue = 1'b0;
    if (rst) begin
      mq[k].delete();
      m_rem[k] = 0; m_nop[k] = 0; m_addr[k] = 0;
      m_data[k] = NOP; m_raddr[k] = 0; m_rv[k] = 1'b0; m_hold[k] = 1'b1;
    end else if (flush) begin
      mq[k].delete();
      m_rem[k] = 0; m_rv[k] = 1'b0; m_hold[k] = 1'b1;
    end else begin
      if (m_rem[k] > 0) begin
        if (m_rem[k] == 1) issue = 1'b1;
        m_rem[k]--;
      end else if (fetch_req) begin
        m_addr[k] = fetch_addr;
        if (ws[k] == 0) issue = 1'b1;
        else m_rem[k] = ws[k];
      end
      if (issue) begin
        if (mq[k].size() > 0) m_data[k] = mq[k].pop_front();
        else begin
          m_data[k] = NOP;
          if (m_nop[k] < 65535) m_nop[k]++;
        end
        m_raddr[k] = m_addr[k];
      end
      m_rv[k]   = issue;
      m_hold[k] = (m_rem[k] == 0);
      if (wr_valid && mq[k].size() < DEPTH) mq[k].push_back(wr_inst);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ic_data[%0d]", k),    ic_data[k],             m_data[k]);
      chk($sformatf("ic_hold[%0d]", k),    32'(ic_hold[k]),        32'(m_hold[k]));
      chk($sformatf("resp_valid[%0d]", k), 32'(resp_valid[k]),     32'(m_rv[k]));
      chk($sformatf("resp_addr[%0d]", k),  resp_addr[k],           m_raddr[k]);
      chk($sformatf("fifo_count[%0d]", k), 32'(fifo_count[k]),     32'(mq[k].size()));
      chk($sformatf("wr_ready[%0d]", k),   32'(wr_ready[k]),       32'(mq[k].size() < DEPTH));
      chk($sformatf("nop_count[%0d]", k),  32'(nop_count[k]),      32'(m_nop[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 1'b0; wr_valid = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    wr_inst = 32'd0; fetch_addr = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_data", ic_data[0], NOP);
    chk("rst_hold", 32'(ic_hold[0]), 32'd1);
    chk("rst_count", 32'(fifo_count[0]), 32'd0);

    // Back-to-back fetches with no wait states
    wr_valid = 1'b1; wr_inst = 32'hC2002000; step();
    wr_inst = 32'h82102005; step();
    wr_valid = 1'b0;
    chk("s1_cnt2", 32'(fifo_count[0]), 32'd2);
    fetch_req = 1'b1; fetch_addr = 32'h40000000; step();
    chk("s1_rv0", 32'(resp_valid[0]), 32'd1);
    chk("s1_d0", ic_data[0], 32'hC2002000);
    chk("s1_a0", resp_addr[0], 32'h40000000);
    chk("s1_h0", 32'(ic_hold[0]), 32'd1);
    fetch_addr = 32'h40000004; step();
    chk("s1_rv1", 32'(resp_valid[0]), 32'd1);
    chk("s1_d1", ic_data[0], 32'h82102005);
    chk("s1_a1", resp_addr[0], 32'h40000004);
    chk("s1_h1", 32'(ic_hold[0]), 32'd1);
    fetch_req = 1'b0; step();
    chk("s1_rvoff", 32'(resp_valid[0]), 32'd0);
    chk("s1_cnt0", 32'(fifo_count[0]), 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Three wait states on a single fetch
    do_reset();
    wr_valid = 1'b1; wr_inst = 32'hA5A50001; step();
    wr_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h00000100; step();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ws_hold_c%0d", i + 1), 32'(ic_hold[1]), 32'd0);
      chk($sformatf("ws_rv_c%0d", i + 1), 32'(resp_valid[1]), 32'd0);
      step();
    end
    chk("ws_resp_hold", 32'(ic_hold[1]), 32'd1);
    chk("ws_resp_rv", 32'(resp_valid[1]), 32'd1);
    chk("ws_resp_data", ic_data[1], 32'hA5A50001);
    chk("ws_resp_addr", resp_addr[1], 32'h00000100);
    step();

    // Empty FIFO returns NOP; push into empty is not bypassed
    do_reset();
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'h300 + 32'(4 * i);
      step();
      chk($sformatf("nop_data%0d", i), ic_data[0], NOP);
      chk($sformatf("nop_rv%0d", i), 32'(resp_valid[0]), 32'd1);
    end
    fetch_req = 1'b0; step();
    chk("nop_cnt3", 32'(nop_count[0]), 32'd3);
    wr_valid = 1'b1; wr_inst = 32'h12345678; fetch_req = 1'b1; step();
    chk("bypass_data", ic_data[0], NOP);
    wr_valid = 1'b0; fetch_req = 1'b0; step();
    chk("bypass_cnt", 32'(fifo_count[0]), 32'd1);
    chk("bypass_nop", 32'(nop_count[0]), 32'd4);

    // Fill, push on a full FIFO alongside a pop, then drain through the wrap
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_inst = 32'h1000 + 32'(i);
      step();
    end
    chk("full_ready", 32'(wr_ready[0]), 32'd0);
    chk("full_cnt", 32'(fifo_count[0]), 32'd16);
    wr_inst = 32'h0000BEEF; fetch_req = 1'b1; fetch_addr = 32'h500; step();
    chk("full_pp_data", ic_data[0], 32'h1000);
    chk("full_pp_cnt", 32'(fifo_count[0]), 32'd16);
    wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fetch_addr = 32'h504 + 32'(4 * i);
      step();
      chk($sformatf("drain%0d", i), ic_data[0], (i == DEPTH - 1) ? 32'h0000BEEF : 32'h1001 + 32'(i));
    end
    fetch_req = 1'b0; step();
    chk("drain_cnt", 32'(fifo_count[0]), 32'd0);

    // Flush in the second wait cycle
    do_reset();
    wr_valid = 1'b1; wr_inst = 32'hCAFE0001; step();
    wr_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h600; step();
    fetch_req = 1'b0; step();
    flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_rv", 32'(resp_valid[1]), 32'd0);
    chk("flush_hold", 32'(ic_hold[1]), 32'd1);
    chk("flush_cnt", 32'(fifo_count[1]), 32'd0);
    chk("flush_nop", 32'(nop_count[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("flush_norv%0d", i), 32'(resp_valid[1]), 32'd0);
    end

    // Reset mid-wait with words queued
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_inst = 32'h7000 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h700; step();
    fetch_req = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_data", ic_data[1], NOP);
    chk("mrst_hold", 32'(ic_hold[1]), 32'd1);
    chk("mrst_rv", 32'(resp_valid[1]), 32'd0);
    chk("mrst_addr", resp_addr[1], 32'd0);
    chk("mrst_cnt", 32'(fifo_count[1]), 32'd0);
    chk("mrst_nop", 32'(nop_count[1]), 32'd0);
    chk("mrst_ready", 32'(wr_ready[1]), 32'd1);
    fetch_req = 1'b1; fetch_addr = 32'h800; step();
    fetch_req = 1'b0;
    chk("mrst_fetch_nop", ic_data[0], NOP);
    chk("mrst_fetch_rv", 32'(resp_valid[0]), 32'd1);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      wr_valid   = ($urandom_range(0, 99) < 55);
      fetch_req  = ($urandom_range(0, 99) < 45);
      wr_inst    = $urandom;
      fetch_addr = $urandom & 32'hFFFFFFFC;
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
